// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS main controller.
// Holds the state enum, opcode and mux encodings, and the packed control word.
package mc_pkg;

  localparam int STATE_W = 4;
  localparam int OP_W    = 6;

  typedef enum logic [STATE_W-1:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ORIEX   = 4'd10,
    IMMWB   = 4'd11,
    JUMP    = 4'd12,
    TRAP    = 4'd13
  } statetype;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_LH    = 6'b100001;
  localparam logic [OP_W-1:0] OP_LB    = 6'b100000;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [2:0] SRCB_B       = 3'b000;
  localparam logic [2:0] SRCB_FOUR    = 3'b001;
  localparam logic [2:0] SRCB_SIMM    = 3'b010;
  localparam logic [2:0] SRCB_SIMM_SH = 3'b011;
  localparam logic [2:0] SRCB_ZIMM    = 3'b100;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [2:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       ne;
    logic       half;
    logic       b;
    logic       illegal;
  } ctrl_t;

  function automatic logic is_legal(input logic [OP_W-1:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_LH, OP_LB,
      OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_J: is_legal = 1'b1;
      default:                               is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_outdec.sv
// Moore output decode: state (plus op for half/b/ne/illegal) -> control word.
// Purely combinational, zero latency; no backpressure.
module mc_outdec
  import mc_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int STATE_W = 4
) (
  input  logic [STATE_W-1:0] state,
  input  logic [OP_W-1:0]    op,
  output ctrl_t              ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.irwrite = 1'b1;
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.pcsrc   = PCSRC_ALU;
        ctrl.aluop   = ALUOP_ADD;
        ctrl.pcwrite = 1'b1;
      end
      DECODE: begin
        ctrl.alusrcb = SRCB_SIMM_SH;
        ctrl.aluop   = ALUOP_ADD;
        ctrl.illegal = !is_legal(op);
      end
      MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_SIMM;
      end
      MEMRD: ctrl.iord = 1'b1;
      MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.half     = (op == OP_LH);
        ctrl.b        = (op == OP_LB);
      end
      MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      EXECUTE: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_B;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      BRANCH: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_B;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = PCSRC_ALUOUT;
        ctrl.branch  = 1'b1;
        ctrl.ne      = (op == OP_BNE);
      end
      ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_SIMM;
      end
      ORIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_ZIMM;
        ctrl.aluop   = ALUOP_OR;
      end
      IMMWB: ctrl.regwrite = 1'b1;
      JUMP: begin
        ctrl.pcsrc   = PCSRC_JUMP;
        ctrl.pcwrite = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      TRAP: ctrl.illegal = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS main controller FSM; 3-5 cycles per instruction, no backpressure.
// ILLEGAL_TRAP_EN: illegal opcodes park in TRAP until reset instead of retiring as a NOP.
module mc_controller
  import mc_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int STATE_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] op,
  input  logic            zero,
  output logic            pcen,
  output logic            iord,
  output logic            memwrite,
  output logic            irwrite,
  output logic            regdst,
  output logic            memtoreg,
  output logic            regwrite,
  output logic            alusrca,
  output logic [2:0]      alusrcb,
  output logic [1:0]      pcsrc,
  output logic [1:0]      aluop,
  output logic            ne,
  output logic            half,
  output logic            b,
  output logic            illegal
);

  logic [STATE_W-1:0] state, state_nxt;
  ctrl_t              ctrl_raw, ctrl;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = FETCH;
    case (state)
      FETCH: state_nxt = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW, OP_LH, OP_LB: state_nxt = MEMADR;
          OP_RTYPE:                   state_nxt = EXECUTE;
          OP_BEQ, OP_BNE:             state_nxt = BRANCH;
          OP_ADDI:                    state_nxt = ADDIEX;
          OP_ORI:                     state_nxt = ORIEX;
          OP_J:                       state_nxt = JUMP;
`ifdef ILLEGAL_TRAP_EN
          default:                    state_nxt = TRAP;
`else
          default:                    state_nxt = FETCH;
`endif
        endcase
      end
      MEMADR:  state_nxt = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_nxt = MEMWB;
      EXECUTE: state_nxt = ALUWB;
      ADDIEX:  state_nxt = IMMWB;
      ORIEX:   state_nxt = IMMWB;
`ifdef ILLEGAL_TRAP_EN
      TRAP:    state_nxt = TRAP;
`endif
      default: state_nxt = FETCH;
    endcase
  end

  mc_outdec #(
    .OP_W    (OP_W),
    .STATE_W (STATE_W)
  ) u_outdec (
    .state (state),
    .op    (op),
    .ctrl  (ctrl_raw)
  );

  // Reset blanks the control word so an abandoned instruction cannot write.
  assign ctrl = reset ? '0 : ctrl_raw;

  assign pcen     = ctrl.pcwrite | (ctrl.branch & (zero ^ ctrl.ne));
  assign iord     = ctrl.iord;
  assign memwrite = ctrl.memwrite;
  assign irwrite  = ctrl.irwrite;
  assign regdst   = ctrl.regdst;
  assign memtoreg = ctrl.memtoreg;
  assign regwrite = ctrl.regwrite;
  assign alusrca  = ctrl.alusrca;
  assign alusrcb  = ctrl.alusrcb;
  assign pcsrc    = ctrl.pcsrc;
  assign aluop    = ctrl.aluop;
  assign ne       = ctrl.ne;
  assign half     = ctrl.half;
  assign b        = ctrl.b;
  assign illegal  = ctrl.illegal;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: stimulus pushes expected control words, a monitor compares.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'b0;
  logic       zero = 1'b0;
  logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [2:0] alusrcb;
  logic [1:0] pcsrc, aluop;
  logic       ne, half, b, illegal;

  int checks = 0;
  int errors = 0;
  logic [18:0] exp_q[$];
  string       name_q[$];

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .ne(ne), .half(half),
    .b(b), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Field order: pcen iord memwrite irwrite regdst memtoreg regwrite alusrca
  //              alusrcb[3] pcsrc[2] aluop[2] ne half b illegal
  function automatic logic [18:0] mk(
    input logic pe, io, mw, irw, rd, mtr, rw, sa,
    input logic [2:0] sb, input logic [1:0] ps, input logic [1:0] ao,
    input logic n, input logic h, input logic bb, input logic il);
    return {pe, io, mw, irw, rd, mtr, rw, sa, sb, ps, ao, n, h, bb, il};
  endfunction

  localparam logic [18:0] E_ZERO    = 19'd0;
  localparam logic [18:0] E_FETCH   = mk(1,0,0,1,0,0,0,0,3'b001,2'b00,2'b00,0,0,0,0);
  localparam logic [18:0] E_DECODE  = mk(0,0,0,0,0,0,0,0,3'b011,2'b00,2'b00,0,0,0,0);
  localparam logic [18:0] E_DEC_ILL = mk(0,0,0,0,0,0,0,0,3'b011,2'b00,2'b00,0,0,0,1);
  localparam logic [18:0] E_MEMADR  = mk(0,0,0,0,0,0,0,1,3'b010,2'b00,2'b00,0,0,0,0);
  localparam logic [18:0] E_MEMRD   = mk(0,1,0,0,0,0,0,0,3'b000,2'b00,2'b00,0,0,0,0);
  localparam logic [18:0] E_MEMWB   = mk(0,0,0,0,0,1,1,0,3'b000,2'b00,2'b00,0,0,0,0);
  localparam logic [18:0] E_MEMWB_H = mk(0,0,0,0,0,1,1,0,3'b000,2'b00,2'b00,0,1,0,0);
  localparam logic [18:0] E_MEMWB_B = mk(0,0,0,0,0,1,1,0,3'b000,2'b00,2'b00,0,0,1,0);
  localparam logic [18:0] E_MEMWR   = mk(0,1,1,0,0,0,0,0,3'b000,2'b00,2'b00,0,0,0,0);
  localparam logic [18:0] E_EXEC    = mk(0,0,0,0,0,0,0,1,3'b000,2'b00,2'b10,0,0,0,0);
  localparam logic [18:0] E_ALUWB   = mk(0,0,0,0,1,0,1,0,3'b000,2'b00,2'b00,0,0,0,0);
  localparam logic [18:0] E_ADDIEX  = mk(0,0,0,0,0,0,0,1,3'b010,2'b00,2'b00,0,0,0,0);
  localparam logic [18:0] E_ORIEX   = mk(0,0,0,0,0,0,0,1,3'b100,2'b00,2'b11,0,0,0,0);
  localparam logic [18:0] E_IMMWB   = mk(0,0,0,0,0,0,1,0,3'b000,2'b00,2'b00,0,0,0,0);
  localparam logic [18:0] E_BNE_T   = mk(1,0,0,0,0,0,0,1,3'b000,2'b01,2'b01,1,0,0,0);
  localparam logic [18:0] E_BNE_N   = mk(0,0,0,0,0,0,0,1,3'b000,2'b01,2'b01,1,0,0,0);
  localparam logic [18:0] E_BEQ_T   = mk(1,0,0,0,0,0,0,1,3'b000,2'b01,2'b01,0,0,0,0);
  localparam logic [18:0] E_BEQ_N   = mk(0,0,0,0,0,0,0,1,3'b000,2'b01,2'b01,0,0,0,0);
  localparam logic [18:0] E_JUMP    = mk(1,0,0,0,0,0,0,0,3'b000,2'b10,2'b00,0,0,0,0);
  localparam logic [18:0] E_TRAP    = mk(0,0,0,0,0,0,0,0,3'b000,2'b00,2'b00,0,0,0,1);

  // One call = one clock cycle: drive inputs, queue what the outputs must be this cycle.
  task automatic step(input logic r, input logic [5:0] o, input logic z,
                      input logic [18:0] e, input string nm);
    reset = r;
    op    = o;
    zero  = z;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [18:0] act;
    logic [18:0] e;
    string       nm;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
             alusrcb, pcsrc, aluop, ne, half, b, illegal};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %b required %b", nm, act, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;
    step(1, 6'b100011, 0, E_ZERO,   "init_rst");
    // LW interrupted in MEMRD by a 3-cycle reset
    step(0, 6'b100011, 0, E_FETCH,  "lwa_fetch");
    step(0, 6'b100011, 0, E_DECODE, "lwa_decode");
    step(0, 6'b100011, 0, E_MEMADR, "lwa_memadr");
    step(1, 6'b100011, 0, E_ZERO,   "rst_memrd_1");
    step(1, 6'b100011, 0, E_ZERO,   "rst_memrd_2");
    step(1, 6'b100011, 0, E_ZERO,   "rst_memrd_3");
    step(0, 6'b111111, 0, E_FETCH,  "rst_release_fetch");
    // full LW; op junk in FETCH must not matter
    step(0, 6'b100011, 0, E_DECODE, "lw_decode");
    step(0, 6'b100011, 0, E_MEMADR, "lw_memadr");
    step(0, 6'b100011, 0, E_MEMRD,  "lw_memrd");
    step(0, 6'b100011, 1, E_MEMWB,  "lw_memwb");
    // LB
    step(0, 6'b100000, 0, E_FETCH,   "lb_fetch");
    step(0, 6'b100000, 0, E_DECODE,  "lb_decode");
    step(0, 6'b100000, 0, E_MEMADR,  "lb_memadr");
    step(0, 6'b100000, 0, E_MEMRD,   "lb_memrd");
    step(0, 6'b100000, 0, E_MEMWB_B, "lb_memwb");
    // LH
    step(0, 6'b100001, 0, E_FETCH,   "lh_fetch");
    step(0, 6'b100001, 0, E_DECODE,  "lh_decode");
    step(0, 6'b100001, 0, E_MEMADR,  "lh_memadr");
    step(0, 6'b100001, 0, E_MEMRD,   "lh_memrd");
    step(0, 6'b100001, 0, E_MEMWB_H, "lh_memwb");
    // SW
    step(0, 6'b101011, 0, E_FETCH,  "sw_fetch");
    step(0, 6'b101011, 0, E_DECODE, "sw_decode");
    step(0, 6'b101011, 0, E_MEMADR, "sw_memadr");
    step(0, 6'b101011, 0, E_MEMWR,  "sw_memwr");
    // RTYPE; op wobbles in EXECUTE/ALUWB without effect
    step(0, 6'b000000, 0, E_FETCH,  "rt_fetch");
    step(0, 6'b000000, 0, E_DECODE, "rt_decode");
    step(0, 6'b101011, 0, E_EXEC,   "rt_execute");
    step(0, 6'b000101, 1, E_ALUWB,  "rt_aluwb");
    // ADDI
    step(0, 6'b001000, 0, E_FETCH,  "addi_fetch");
    step(0, 6'b001000, 0, E_DECODE, "addi_decode");
    step(0, 6'b001000, 0, E_ADDIEX, "addi_ex");
    step(0, 6'b001000, 0, E_IMMWB,  "addi_wb");
    // ORI
    step(0, 6'b001101, 0, E_FETCH,  "ori_fetch");
    step(0, 6'b001101, 0, E_DECODE, "ori_decode");
    step(0, 6'b001101, 0, E_ORIEX,  "ori_ex");
    step(0, 6'b001101, 0, E_IMMWB,  "ori_wb");
    // branches, both polarities, taken and not taken
    step(0, 6'b000101, 0, E_FETCH,  "bne_t_fetch");
    step(0, 6'b000101, 0, E_DECODE, "bne_t_decode");
    step(0, 6'b000101, 0, E_BNE_T,  "bne_taken");
    step(0, 6'b000101, 1, E_FETCH,  "bne_n_fetch");
    step(0, 6'b000101, 1, E_DECODE, "bne_n_decode");
    step(0, 6'b000101, 1, E_BNE_N,  "bne_not_taken");
    step(0, 6'b000100, 1, E_FETCH,  "beq_t_fetch");
    step(0, 6'b000100, 1, E_DECODE, "beq_t_decode");
    step(0, 6'b000100, 1, E_BEQ_T,  "beq_taken");
    step(0, 6'b000100, 0, E_FETCH,  "beq_n_fetch");
    step(0, 6'b000100, 0, E_DECODE, "beq_n_decode");
    step(0, 6'b000100, 0, E_BEQ_N,  "beq_not_taken");
    // J
    step(0, 6'b000010, 0, E_FETCH,  "j_fetch");
    step(0, 6'b000010, 0, E_DECODE, "j_decode");
    step(0, 6'b000010, 0, E_JUMP,   "j_jump");
    // illegal opcode
    step(0, 6'b111111, 0, E_FETCH,   "ill_fetch");
    step(0, 6'b111111, 0, E_DEC_ILL, "ill_decode");
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++)
      step(0, (i % 2 == 0) ? 6'b100011 : 6'b000010, i[0], E_TRAP, "trap_hold");
    step(1, 6'b000010, 0, E_ZERO,  "trap_reset");
    step(0, 6'b000010, 0, E_FETCH, "trap_exit_fetch");
`else
    step(0, 6'b000010, 0, E_FETCH,  "ill_nop_fetch");
`endif
    step(0, 6'b000010, 0, E_DECODE, "post_ill_decode");
    step(0, 6'b000010, 0, E_JUMP,   "post_ill_jump");
    step(0, 6'b000000, 0, E_FETCH,  "final_fetch");

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle main controller FSM for the MIPS core. It replaces single-cycle main decoding with a state-sequenced control path that shares one memory and one ALU across instruction steps.
- Takes the opcode from the instruction register and drives datapath enables and muxes each cycle.
- Sits beside the existing aludec, which still consumes aluop and funct.

Parameters:
- OP_W, 6, opcode width.
- STATE_W, 4, state register width; must hold all states in the shared package.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- op  in  OP_W  opcode from the instruction register, valid from DECODE onward.
- zero  in  1  ALU zero flag, sampled combinationally in BRANCH.
- pcen  out  1  PC register write enable: pcwrite | (branch & (zero ^ ne)).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memwrite  out  1  data memory write strobe.
- irwrite  out  1  instruction register load.
- regdst  out  1  write register select: 1 = rd, 0 = rt.
- memtoreg  out  1  write-back data select: 1 = memory data register, 0 = ALUOut.
- regwrite  out  1  register file write enable.
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A.
- alusrcb  out  3  ALU B select: 000 = B, 001 = 4, 010 = signimm, 011 = signimm<<2, 100 = zeroimm.
- pcsrc  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- aluop  out  2  to aludec: 00 = add, 01 = sub, 10 = funct, 11 = or.
- ne  out  1  branch polarity: 1 = BNE.
- half  out  1  load halfword, valid in MEMWB.
- b  out  1  load byte, valid in MEMWB.
- illegal  out  1  illegal opcode detected.

Behaviour:
- Registered state only; all outputs are a Moore decode of the state (plus op for half/b/ne). While reset = 1, every output is forced to 0. On the clk edge with reset = 1, state <= FETCH, also when reset arrives mid-instruction; the partial instruction is abandoned with no writes.
- Default for every output not listed in a state is 0.
- FETCH: iord = 0, irwrite = 1, alusrca = 0, alusrcb = 001, aluop = 00, pcsrc = 00, pcwrite = 1. Next state DECODE.
- DECODE: alusrca = 0, alusrcb = 011, aluop = 00 (branch target into ALUOut). Next state by op:
  - LW 100011, SW 101011, LH 100001, LB 100000 -> MEMADR
  - RTYPE 000000 -> EXECUTE
  - BEQ 000100, BNE 000101 -> BRANCH
  - ADDI 001000 -> ADDIEX
  - ORI 001101 -> ORIEX
  - J 000010 -> JUMP
  - any other op -> ILLEGAL handling (see Optional Feature)
- MEMADR: alusrca = 1, alusrcb = 010, aluop = 00. SW -> MEMWR; otherwise -> MEMRD.
- MEMRD: iord = 1 -> MEMWB.
- MEMWB: regdst = 0, memtoreg = 1, regwrite = 1; half = 1 for LH, b = 1 for LB -> FETCH.
- MEMWR: iord = 1, memwrite = 1 -> FETCH.
- EXECUTE: alusrca = 1, alusrcb = 000, aluop = 10 -> ALUWB.
- ALUWB: regdst = 1, memtoreg = 0, regwrite = 1 -> FETCH.
- BRANCH: alusrca = 1, alusrcb = 000, aluop = 01, pcsrc = 01, branch = 1; ne = 1 for BNE -> FETCH.
  - Taken: BEQ when zero = 1; BNE when zero = 0.
- ADDIEX: alusrca = 1, alusrcb = 010, aluop = 00 -> IMMWB.
- ORIEX: alusrca = 1, alusrcb = 100, aluop = 11 -> IMMWB.
- IMMWB: regdst = 0, memtoreg = 0, regwrite = 1 -> FETCH.
- JUMP: pcsrc = 10, pcwrite = 1 -> FETCH.
- Latency in cycles:
  - LW/LH/LB = 5
  - SW, RTYPE, ADDI, ORI = 4
  - BEQ, BNE, J = 3
- op is sampled only in DECODE, MEMADR, MEMWB and BRANCH; op changes in other states have no effect.
- Unused state encodings -> FETCH on the next edge, with all outputs 0 in that cycle.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: an illegal op in DECODE -> TRAP. TRAP holds forever: illegal = 1, all enables 0. Only reset exits TRAP.
- Undefined: an illegal op in DECODE drives illegal = 1 for that DECODE cycle only and goes to FETCH, so the instruction executes as a 2-cycle NOP. The TRAP state is not built.

Decomposition:
- Package mc_pkg holds:
  - enum statetype (FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ORIEX, IMMWB, JUMP, TRAP)
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_LH, OP_LB, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_J)
  - alusrcb, pcsrc and aluop encodings as localparams
- One sub-module, mc_outdec: combinational state+op -> control word.
- The state register and next-state logic stay in mc_controller.

Test Plan:
- Reset held 3 cycles mid-LW (state MEMRD) -> all outputs 0 during reset; first cycle after release shows FETCH (pcen = 1, irwrite = 1, alusrcb = 001).
- op = 100011 (LW) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, then FETCH; regwrite = 1 and memtoreg = 1 only in cycle 5; half = 0, b = 0.
- op = 100000 (LB) -> same 5-cycle path with b = 1 in MEMWB; op = 100001 (LH) -> half = 1 in MEMWB.
- op = 000101 (BNE) with zero = 0 -> pcen = 1, pcsrc = 01 in cycle 3. With zero = 1 -> pcen = 0. BEQ is the mirror case.
- op = 001101 (ORI) -> alusrcb = 100 and aluop = 11 in cycle 3; regwrite = 1, regdst = 0 in cycle 4. op = 000010 (J) -> pcsrc = 10, pcen = 1 in cycle 3.
- op = 111111:
  - with ILLEGAL_TRAP_EN: illegal stays 1 and pcen stays 0 for 10+ cycles until reset.
  - without it: illegal pulses 1 for one cycle, then FETCH.
